// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the MIPS datapath/memory.
// master = controller side, slave = datapath side.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] ALUOp;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               illegal;
    logic [CNT_W-1:0]   instret;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ALUOp, reg_write, reg_dst, mem_to_reg,
               illegal, instret
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ALUOp, reg_write, reg_dst, mem_to_reg,
               illegal, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU through fetch/decode/execute/
// memory/writeback, drives all write enables and counts retired instructions.
module mc_ctrl #(
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rstn,
    mc_ctrl_if.master    bus
);
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALUOP_EQL  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALUOP_LUI  = ALUOP_W'(4);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM,
        S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_instret;
    logic               w_retire;

    logic               w_mem_req, w_mem_read, w_mem_write;
    logic               w_ir_write, w_pc_write;
    logic [1:0]         w_pc_src;
    logic               w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_reg_write, w_reg_dst, w_mem_to_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Outputs stay at their idle values while rstn is low, so a reset mid-instruction
    // can never leak a write.
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 2'b00;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = ALUOP_ADDU;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        if (rstn) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req   = 1'b1;
                    w_mem_read  = 1'b1;
                    w_alu_src_b = 2'b01;
                    w_ir_write  = bus.mem_ready;
                    w_pc_write  = bus.mem_ready;
                    if (bus.mem_ready)
                        w_next = S_DECODE;
                end
                S_DECODE: begin
                    w_alu_src_b = 2'b11;
                    case (bus.opcode)
                        6'b000000:            w_next = S_EXEC_R;
                        6'b001101, 6'b001111: w_next = S_EXEC_I;
                        6'b100011, 6'b101011: w_next = S_ADDR;
                        6'b000100:            w_next = S_BRANCH;
                        6'b000010:            w_next = S_JUMP;
                        default:              w_next = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    w_alu_src_a = 1'b1;
                    w_next      = S_WB_R;
                    case (bus.funct)
                        6'b100001: w_alu_op = ALUOP_ADDU;
                        6'b100011: w_alu_op = ALUOP_SUBU;
                        6'b100101: w_alu_op = ALUOP_OR;
                        default:   w_next   = S_TRAP;
                    endcase
                end
                S_EXEC_I: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                    w_alu_op    = (bus.opcode == 6'b001111) ? ALUOP_LUI : ALUOP_OR;
                    w_next      = S_WB_I;
                end
                S_ADDR: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                    w_next      = S_MEM;
                end
                S_MEM: begin
                    // IR still holds lw/sw here; they differ only in opcode bit 3.
                    w_mem_req   = 1'b1;
                    w_mem_read  = ~bus.opcode[3];
                    w_mem_write = bus.opcode[3];
                    if (bus.mem_ready)
                        w_next = bus.opcode[3] ? S_FETCH : S_WB_LW;
                end
                S_WB_R: begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 1'b1;
                    w_next      = S_FETCH;
                end
                S_WB_I: begin
                    w_reg_write = 1'b1;
                    w_next      = S_FETCH;
                end
                S_WB_LW: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_next       = S_FETCH;
                end
                S_BRANCH: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = ALUOP_EQL;
                    w_pc_src    = 2'b01;
                    w_pc_write  = bus.zero;
                    w_next      = S_FETCH;
                end
                S_JUMP: begin
                    w_pc_src   = 2'b10;
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
                end
                S_TRAP:  w_next = S_TRAP;
                default: w_next = S_FETCH;
            endcase
        end
    end

    // Every path back into FETCH from another state completes an instruction.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.ALUOp      = w_alu_op;
    assign bus.reg_write  = w_reg_write;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.illegal    = r_illegal;
    assign bus.instret    = r_instret;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction control-word schedules built from the instruction
// rules, driven with random memory/fetch waits and checked every cycle.
module tb_mc_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;
    localparam logic [AW-1:0] OP_ADDU = 5'd0;
    localparam logic [AW-1:0] OP_SUBU = 5'd1;
    localparam logic [AW-1:0] OP_OR   = 5'd2;
    localparam logic [AW-1:0] OP_EQL  = 5'd3;
    localparam logic [AW-1:0] OP_LUI  = 5'd4;

    typedef struct packed {
        logic          mem_req, mem_read, mem_write, ir_write, pc_write;
        logic [1:0]    pc_src;
        logic          a;
        logic [1:0]    b;
        logic [AW-1:0] aluop;
        logic          reg_write, reg_dst, mem_to_reg;
    } ctrl_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUOP_W(AW), .CNT_W(CW)) bus ();
    mc_ctrl #(.ALUOP_W(AW), .CNT_W(CW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int            errs = 0;
    int            checks = 0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_ill = 1'b0;

    function automatic ctrl_t idle();
        ctrl_t c = '0;
        c.aluop = OP_ADDU;
        return c;
    endfunction

    function automatic ctrl_t act();
        ctrl_t c;
        c.mem_req = bus.mem_req;     c.mem_read = bus.mem_read;
        c.mem_write = bus.mem_write; c.ir_write = bus.ir_write;
        c.pc_write = bus.pc_write;   c.pc_src = bus.pc_src;
        c.a = bus.alu_src_a;         c.b = bus.alu_src_b;
        c.aluop = bus.ALUOp;         c.reg_write = bus.reg_write;
        c.reg_dst = bus.reg_dst;     c.mem_to_reg = bus.mem_to_reg;
        return c;
    endfunction

    task automatic check(string name, ctrl_t exp, bit chk_alu, bit chk_regs);
        ctrl_t a = act();
        ctrl_t e = exp;
        bit ok;
        if (!chk_alu) begin
            a.aluop = '0;
            e.aluop = '0;
        end
        ok = (a === e) && !(a.mem_read && a.mem_write) && !(a.reg_write && a.pc_write);
        if (chk_regs)
            ok = ok && (bus.illegal === m_ill) && (bus.instret === m_cnt);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s @%0t: got ctrl=%h ill=%b cnt=%0d, want ctrl=%h ill=%b cnt=%0d",
                     name, $time, a, bus.illegal, bus.instret, e, m_ill, m_cnt);
        end
    endtask

    task automatic lit(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Called just after a rising edge: drive, compare on the falling edge, return after next rise.
    task automatic step(string name, ctrl_t e, logic rdy, logic z, logic [5:0] op,
                        logic [5:0] fn, bit chk_alu);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = op;
        bus.funct     = fn;
        @(negedge clk);
        check(name, e, chk_alu, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n, bit regs_known);
        rstn = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = 1'($urandom);
            bus.zero      = 1'($urandom);
            bus.opcode    = 6'($urandom);
            bus.funct     = 6'($urandom);
            @(negedge clk);
            check("reset", idle(), 1'b1, regs_known || i > 0);
            @(posedge clk);
            #1;
            m_cnt = '0;
            m_ill = 1'b0;
        end
        rstn = 1'b1;
    endtask

    task automatic trap_cycles(int n, logic [5:0] op, logic [5:0] fn);
        m_ill = 1'b1;
        for (int i = 0; i < n; i++)
            step("trap", idle(), 1'($urandom), 1'($urandom), op, fn, 1'b1);
    endtask

    function automatic bit funct_ok(logic [5:0] fn);
        return fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100101;
    endfunction

    // Plays one instruction; abort=1 resets during the first MEM cycle.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw, logic z,
                             bit abort, output int cyc, output bit trapped);
        ctrl_t c;
        cyc = 0;
        trapped = 1'b0;
        c = idle(); c.mem_req = 1; c.mem_read = 1; c.b = 2'b01;
        for (int i = 0; i < fw; i++) begin
            step("fetch_wait", c, 1'b0, 1'($urandom), 6'($urandom), 6'($urandom), 1'b1);
            cyc++;
        end
        c.ir_write = 1; c.pc_write = 1;
        step("fetch", c, 1'b1, 1'($urandom), 6'($urandom), 6'($urandom), 1'b1);
        cyc++;
        c = idle(); c.b = 2'b11;
        step("decode", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
        cyc++;
        case (op)
            6'b000000: begin
                c = idle(); c.a = 1;
                c.aluop = (fn == 6'b100011) ? OP_SUBU : (fn == 6'b100101) ? OP_OR : OP_ADDU;
                step("exec_r", c, 1'($urandom), 1'($urandom), op, fn, funct_ok(fn));
                cyc++;
                if (funct_ok(fn)) begin
                    c = idle(); c.reg_write = 1; c.reg_dst = 1;
                    step("wb_r", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
                    cyc++;
                    m_cnt++;
                end else begin
                    trapped = 1'b1;
                end
            end
            6'b001101, 6'b001111: begin
                c = idle(); c.a = 1; c.b = 2'b10;
                c.aluop = (op == 6'b001111) ? OP_LUI : OP_OR;
                step("exec_i", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
                c = idle(); c.reg_write = 1;
                step("wb_i", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
                cyc += 2;
                m_cnt++;
            end
            6'b100011, 6'b101011: begin
                c = idle(); c.a = 1; c.b = 2'b10;
                step("addr", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
                cyc++;
                c = idle(); c.mem_req = 1;
                c.mem_read = (op == 6'b100011); c.mem_write = (op == 6'b101011);
                if (abort) begin
                    step("mem_pre_abort", c, 1'b0, 1'($urandom), op, fn, 1'b1);
                    do_reset(1, 1'b1);
                    return;
                end
                for (int i = 0; i < mw; i++) begin
                    step("mem_wait", c, 1'b0, 1'($urandom), op, fn, 1'b1);
                    cyc++;
                end
                step("mem", c, 1'b1, 1'($urandom), op, fn, 1'b1);
                cyc++;
                if (op == 6'b100011) begin
                    c = idle(); c.reg_write = 1; c.mem_to_reg = 1;
                    step("wb_lw", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
                    cyc++;
                end
                m_cnt++;
            end
            6'b000100: begin
                c = idle(); c.a = 1; c.aluop = OP_EQL; c.pc_src = 2'b01; c.pc_write = z;
                step("branch", c, 1'($urandom), z, op, fn, 1'b1);
                cyc++;
                m_cnt++;
            end
            6'b000010: begin
                c = idle(); c.pc_src = 2'b10; c.pc_write = 1;
                step("jump", c, 1'($urandom), 1'($urandom), op, fn, 1'b1);
                cyc++;
                m_cnt++;
            end
            default: trapped = 1'b1;
        endcase
        if (trapped)
            trap_cycles(3, op, fn);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bit tr;
        logic [5:0] ops [9];
        logic [5:0] fns [9];
        ops = '{6'h00, 6'h00, 6'h00, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        fns = '{6'b100001, 6'b100011, 6'b100101, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        bus.mem_ready = 0; bus.zero = 0; bus.opcode = 0; bus.funct = 0;
        @(posedge clk);
        #1;
        do_reset(2, 1'b0);
        lit("reset_instret", 64'(bus.instret), 64'd0);

        run_instr(6'h00, 6'b100001, 5, 0, 0, 0, cyc, tr);
        lit("addu_fetchwait_cycles", 64'(cyc), 64'd9);
        lit("addu_instret", 64'(bus.instret), 64'd1);
        run_instr(6'h00, 6'b100001, 0, 0, 0, 0, cyc, tr);
        lit("addu_cycles", 64'(cyc), 64'd4);
        run_instr(6'b100011, 6'h00, 0, 3, 0, 0, cyc, tr);
        lit("lw_wait3_cycles", 64'(cyc), 64'd8);
        run_instr(6'b101011, 6'h00, 0, 0, 0, 0, cyc, tr);
        lit("sw_cycles", 64'(cyc), 64'd4);
        run_instr(6'b000100, 6'h00, 0, 0, 1, 0, cyc, tr);
        lit("beq_taken_cycles", 64'(cyc), 64'd3);
        run_instr(6'b000100, 6'h00, 0, 0, 0, 0, cyc, tr);
        lit("beq_instret", 64'(bus.instret), 64'd6);
        run_instr(6'b000010, 6'h00, 0, 0, 0, 0, cyc, tr);
        lit("j_cycles", 64'(cyc), 64'd3);
        run_instr(6'b001101, 6'h00, 0, 0, 0, 0, cyc, tr);
        run_instr(6'b001111, 6'h00, 0, 0, 0, 0, cyc, tr);
        lit("lui_cycles", 64'(cyc), 64'd4);
        run_instr(6'b100011, 6'h00, 0, 0, 0, 0, cyc, tr);
        lit("lw_cycles", 64'(cyc), 64'd5);
        lit("mix_instret", 64'(bus.instret), 64'd10);

        run_instr(6'b111111, 6'h00, 0, 0, 0, 0, cyc, tr);
        lit("illegal_set", 64'(bus.illegal), 64'd1);
        do_reset(1, 1'b1);
        lit("illegal_cleared", 64'(bus.illegal), 64'd0);
        lit("trap_reset_instret", 64'(bus.instret), 64'd0);

        run_instr(6'h00, 6'b100101, 1, 0, 0, 0, cyc, tr);
        run_instr(6'b101011, 6'h00, 0, 2, 0, 1, cyc, tr);
        lit("sw_abort_instret", 64'(bus.instret), 64'd0);
        run_instr(6'h00, 6'b000000, 0, 0, 0, 0, cyc, tr);
        do_reset(1, 1'b1);

        for (int n = 0; n < 250; n++) begin
            int r = $urandom_range(0, 24);
            logic [5:0] op, fn;
            if (r == 0) begin
                op = 6'h00;
                do fn = 6'($urandom); while (funct_ok(fn));
            end else if (r == 1) begin
                op = ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b000011;
                fn = 6'($urandom);
            end else begin
                int k = $urandom_range(0, 8);
                op = ops[k];
                fn = fns[k];
            end
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
                      1'b0, cyc, tr);
            if (tr)
                do_reset($urandom_range(1, 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
